a8_bus_sequencer: RTL and testbench
===================================

# a8_bus_sequencer

Per-cycle sequencer for the Atari 8-bit cartridge/PBI bus, running in the clk200 domain. It tracks each phi2 (a8_clk) cycle and samples address, R/W and data at fixed delays after the phi2 rise. It drives a8_extsel_n and a8_mpd_n for a configurable claimed address window. Every captured bus cycle is pushed into a 4-deep event FIFO with a valid/ready handshake for downstream consumers such as the bus monitor and register files.

## Interface
- SYNC_STAGES, 2: synchronizer depth for a8_clk, a8_rw_n, a8_halt_n, a8_rst_n.
- ADDR_DLY, 8: clk200 cycles after phi2-rise detect at which address, R/W and HALT are sampled.
- DATA_DLY, 40: clk200 cycles after phi2-rise detect at which data is sampled; must be greater than ADDR_DLY.
- HOLD_CYCLES, 4: clk200 cycles a8_extsel_n/a8_mpd_n stay asserted after phi2-fall detect.
- clk200  in  1  200 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- a8_clk  in  1  A8 phi2, asynchronous.
- a8_rw_n  in  1  A8 R/W, asynchronous.
- a8_halt_n  in  1  A8 /HALT; low means ANTIC DMA cycle.
- a8_rst_n  in  1  A8 /RST.
- a8_addr  in  16  A8 address bus.
- a8_data  in  8  A8 data bus.
- cfg_base  in  16  claim window base.
- cfg_mask  in  16  claim window mask; a cycle matches when (addr & mask) == (base & mask).
- cfg_claim_en  in  1  enables a8_extsel_n assertion.
- cfg_mpd_en  in  1  enables a8_mpd_n for $D800–$DFFF.
- ovf_clr  in  1  one-cycle pulse that clears ovf.
- a8_extsel_n  out  1  external select, active low.
- a8_mpd_n  out  1  math-pack disable, active low.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head.
- evt_addr  out  16  address of the head event.
- evt_data  out  8  data of the head event.
- evt_rw_n  out  1  R/W of the head event.
- evt_dma  out  1  head event was a HALT (DMA) cycle.
- ovf  out  1  sticky: an event was dropped.
- drop_cnt  out  8  dropped-event count, saturating at 255.
- short_err  out  1  one-cycle pulse: phi2 fell before DATA_DLY.

## Operation
- a8_clk, a8_rw_n, a8_halt_n and a8_rst_n pass through SYNC_STAGES flops. Rise detect = synced phi2 high and previous synced phi2 low; fall detect is the inverse.
- a8_addr and a8_data are sampled raw into capture registers. They are quasi-static at the sample points.
- Cycle counter cnt is 6 bits. It clears on the rise-detect cycle (cnt=0) and increments while in ADDR_WAIT or DATA_WAIT.
- IDLE: wait for rise detect, then go to ADDR_WAIT.
- ADDR_WAIT: at cnt==ADDR_DLY, latch addr, rw_n and dma (=~halt_n), and compute claim = cfg_claim_en & match & ~dma, and mpd = cfg_mpd_en & (addr[15:11]==5'b11011). Go to DATA_WAIT.
- DATA_WAIT: at cnt==DATA_DLY, latch data, push the event, and go to WAIT_FALL.
- WAIT_FALL: on fall detect, go to HOLD.
- HOLD: count HOLD_CYCLES, deassert a8_extsel_n/a8_mpd_n, then return to IDLE.
- Fall detect in ADDR_WAIT or DATA_WAIT: pulse short_err, push nothing, go to HOLD.
- Rise detect in HOLD: deassert the outputs and restart at ADDR_WAIT with cnt=0.
- A low synced a8_rst_n forces IDLE and drives a8_extsel_n and a8_mpd_n high the next cycle. The FIFO, ovf and drop_cnt are preserved.
- FIFO: 4 entries of {dma, rw_n, data, addr}; evt_* are driven from the head.
- A pop occurs when evt_valid & evt_ready.
- A push when the FIFO is full and there is no simultaneous pop is dropped: set ovf and increment drop_cnt (saturating).
- A push and pop in the same cycle when full: both succeed, no drop.
- ovf_clr clears ovf. If a drop happens in the same cycle, the set wins.

## Timing
- Reset values: a8_extsel_n=1, a8_mpd_n=1, evt_valid=0, evt_addr=0, evt_data=0, evt_rw_n=1, evt_dma=0, ovf=0, drop_cnt=0, short_err=0, state IDLE, FIFO empty.
- a8_extsel_n/a8_mpd_n go low on the cycle after the ADDR_DLY sample (registered). They go high on the cycle after the HOLD count expires.
- evt_valid rises one cycle after a push into an empty FIFO. FIFO latency is 1 cycle.
- Input-edge to internal-detect latency is SYNC_STAGES+1 cycles.

## Test plan
- Claimed write: base=$D500, mask=$FF00, claim_en=1; write $5A to $D500 with phi2 high 56 cycles. Required: a8_extsel_n low from rise+ADDR_DLY+1 until fall+HOLD; one event with addr=$D500, data=$5A, rw_n=0, dma=0.
- Unclaimed read at $0600 with bus data $A9. Required: a8_extsel_n stays high; event addr=$0600, data=$A9, rw_n=1.
- a8_halt_n low during a cycle at $D510. Required: no a8_extsel_n assertion; event has dma=1.
- cfg_mpd_en=1, reads at $D800 and $DFFF. Required: a8_mpd_n low each cycle. Read at $E000: a8_mpd_n stays high.
- evt_ready held low over 6 bus cycles. Required: 4 events queued, ovf=1, drop_cnt=2. Then ovf_clr plus draining returns the first 4 events in order.
- Short phi2 pulse (high 20 cycles): short_err pulses once, no event. Separately, a8_rst_n low mid-DATA_WAIT: no event, outputs high, back in IDLE.

Source files
------------

// File: rtl/a8_bus_sequencer_if.sv
// rtl/a8_bus_sequencer_if.sv - captured bus-cycle event stream (valid/ready) between sequencer and consumers
interface a8_bus_sequencer_if;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_addr;
  logic [7:0]  evt_data;
  logic        evt_rw_n;
  logic        evt_dma;

  modport master (
    output evt_valid,
    output evt_addr,
    output evt_data,
    output evt_rw_n,
    output evt_dma,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_addr,
    input  evt_data,
    input  evt_rw_n,
    input  evt_dma,
    output evt_ready
  );
endinterface

// File: rtl/a8_bus_sequencer.sv
// rtl/a8_bus_sequencer.sv - per-phi2-cycle A8 bus sequencer with claim/MPD drive and 4-deep event FIFO
module a8_bus_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_DLY    = 8,
  parameter int DATA_DLY    = 40,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk200,
  input  logic        rst_n,
  input  logic        a8_clk_i,
  input  logic        a8_rw_n_i,
  input  logic        a8_halt_n_i,
  input  logic        a8_rst_n_i,
  input  logic [15:0] a8_addr_i,
  input  logic [7:0]  a8_data_i,
  input  logic [15:0] cfg_base_i,
  input  logic [15:0] cfg_mask_i,
  input  logic        cfg_claim_en_i,
  input  logic        cfg_mpd_en_i,
  input  logic        ovf_clr_i,
  output logic        a8_extsel_n_o,
  output logic        a8_mpd_n_o,
  output logic        ovf_o,
  output logic [7:0]  drop_cnt_o,
  output logic        short_err_o,
  a8_bus_sequencer_if.master evt
);

  localparam logic [5:0]        ADDR_DLY_C  = 6'(ADDR_DLY);
  localparam logic [5:0]        DATA_DLY_C  = 6'(DATA_DLY);
  localparam int                HOLD_W      = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR_WAIT = 3'd1,
    S_DATA_WAIT = 3'd2,
    S_WAIT_FALL = 3'd3,
    S_HOLD      = 3'd4
  } state_e;

  // Synchronizer bit order: {a8_rst_n, a8_halt_n, a8_rw_n, a8_clk}
  logic [3:0] sync_q [SYNC_STAGES];
  logic       phi2_prev_q;
  logic       phi2_s, rw_n_s, halt_n_s, a8_rst_n_s;
  logic       rise, fall;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // FSM control strobes
  logic cnt_clr, cnt_inc, hold_clr, hold_inc;
  logic addr_latch, evt_push, short_pulse, out_release;

  // Captured cycle attributes
  logic [15:0] addr_q;
  logic        rw_n_q, dma_q;
  logic        extsel_n_q, mpd_n_q, short_err_q;
  logic        claim_c, mpd_c;

  // Event FIFO {dma, rw_n, data, addr}
  logic [25:0] fifo_mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        fifo_valid, fifo_full, pop, wr_en, drop;
  logic [25:0] head;
  logic        ovf_q;
  logic [7:0]  drop_cnt_q;

  // Bring the asynchronous A8 control lines into clk200 and remember last phi2 level
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1110;
      phi2_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {a8_rst_n_i, a8_halt_n_i, a8_rw_n_i, a8_clk_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      phi2_prev_q <= sync_q[SYNC_STAGES-1][0];
    end
  end

  assign phi2_s     = sync_q[SYNC_STAGES-1][0];
  assign rw_n_s     = sync_q[SYNC_STAGES-1][1];
  assign halt_n_s   = sync_q[SYNC_STAGES-1][2];
  assign a8_rst_n_s = sync_q[SYNC_STAGES-1][3];
  assign rise       = phi2_s & ~phi2_prev_q;
  assign fall       = ~phi2_s & phi2_prev_q;

  // Claim decisions use the raw address, which is quasi-static at the sample point
  assign claim_c = cfg_claim_en_i & ((a8_addr_i & cfg_mask_i) == (cfg_base_i & cfg_mask_i)) & halt_n_s;
  assign mpd_c   = cfg_mpd_en_i & (a8_addr_i[15:11] == 5'b11011);

  // FSM state register
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: A8 reset dominates, an early phi2 fall aborts to HOLD
  always_comb begin
    state_d = state_q;
    if (!a8_rst_n_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (rise) state_d = S_ADDR_WAIT;
        S_ADDR_WAIT: begin
          if (fall)                    state_d = S_HOLD;
          else if (cnt_q == ADDR_DLY_C) state_d = S_DATA_WAIT;
        end
        S_DATA_WAIT: begin
          if (fall)                    state_d = S_HOLD;
          else if (cnt_q == DATA_DLY_C) state_d = S_WAIT_FALL;
        end
        S_WAIT_FALL: if (fall) state_d = S_HOLD;
        S_HOLD: begin
          if (rise)                           state_d = S_ADDR_WAIT;
          else if (hold_cnt_q == HOLD_LAST_C) state_d = S_IDLE;
        end
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: per-state strobes for counters, capture, push and pin release
  always_comb begin
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    hold_clr    = 1'b0;
    hold_inc    = 1'b0;
    addr_latch  = 1'b0;
    evt_push    = 1'b0;
    short_pulse = 1'b0;
    out_release = 1'b0;
    if (!a8_rst_n_s) begin
      out_release = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:      cnt_clr = rise;
        S_ADDR_WAIT: begin
          if (fall) begin
            short_pulse = 1'b1;
            hold_clr    = 1'b1;
          end else begin
            cnt_inc    = 1'b1;
            addr_latch = (cnt_q == ADDR_DLY_C);
          end
        end
        S_DATA_WAIT: begin
          if (fall) begin
            short_pulse = 1'b1;
            hold_clr    = 1'b1;
          end else begin
            cnt_inc  = 1'b1;
            evt_push = (cnt_q == DATA_DLY_C);
          end
        end
        S_WAIT_FALL: hold_clr = fall;
        S_HOLD: begin
          if (rise) begin
            out_release = 1'b1;
            cnt_clr     = 1'b1;
          end else begin
            hold_inc    = 1'b1;
            out_release = (hold_cnt_q == HOLD_LAST_C);
          end
        end
        default: out_release = 1'b1;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)      cnt_d = 6'd0;
    else if (cnt_inc) cnt_d = cnt_q + 6'd1;
    hold_cnt_d = hold_cnt_q;
    if (hold_clr)      hold_cnt_d = '0;
    else if (hold_inc) hold_cnt_d = hold_cnt_q + 1'b1;
  end

  // Cycle counters and registered bus-pin drive
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 6'd0;
      hold_cnt_q  <= '0;
      addr_q      <= 16'd0;
      rw_n_q      <= 1'b1;
      dma_q       <= 1'b0;
      extsel_n_q  <= 1'b1;
      mpd_n_q     <= 1'b1;
      short_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      short_err_q <= short_pulse;
      if (addr_latch) begin
        addr_q <= a8_addr_i;
        rw_n_q <= rw_n_s;
        dma_q  <= ~halt_n_s;
      end
      if (out_release) begin
        extsel_n_q <= 1'b1;
        mpd_n_q    <= 1'b1;
      end else if (addr_latch) begin
        extsel_n_q <= ~claim_c;
        mpd_n_q    <= ~mpd_c;
      end
    end
  end

  assign fifo_valid = (count_q != 3'd0);
  assign fifo_full  = (count_q == 3'd4);
  assign pop        = fifo_valid & evt.evt_ready;
  assign wr_en      = evt_push & (~fifo_full | pop);
  assign drop       = evt_push & fifo_full & ~pop;
  assign head       = fifo_mem_q[rd_ptr_q];

  // FIFO storage needs no reset: the head is only exposed while valid
  always_ff @(posedge clk200) begin
    if (wr_en) fifo_mem_q[wr_ptr_q] <= {dma_q, rw_n_q, a8_data_i, addr_q};
  end

  // FIFO pointers, occupancy and overflow bookkeeping (drop set beats clear)
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, wr_en} - {2'b00, pop};
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end else if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = fifo_valid;
  assign evt.evt_addr  = fifo_valid ? head[15:0]  : 16'd0;
  assign evt.evt_data  = fifo_valid ? head[23:16] : 8'd0;
  assign evt.evt_rw_n  = fifo_valid ? head[24]    : 1'b1;
  assign evt.evt_dma   = fifo_valid ? head[25]    : 1'b0;

  assign a8_extsel_n_o = extsel_n_q;
  assign a8_mpd_n_o    = mpd_n_q;
  assign ovf_o         = ovf_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign short_err_o   = short_err_q;

endmodule

// File: tb/tb_a8_bus_sequencer.sv
// tb/tb_a8_bus_sequencer.sv - self-checking bench for a8_bus_sequencer
module tb_a8_bus_sequencer;
  localparam int SYNC_STAGES = 2;
  localparam int ADDR_DLY    = 8;
  localparam int DATA_DLY    = 40;
  localparam int HOLD_CYCLES = 4;
  // Offsets (in clk200 cycles from the phi2 edge being driven) of the observable pin changes
  localparam int T_ASSERT  = SYNC_STAGES + 1 + ADDR_DLY + 1;
  localparam int T_RELEASE = SYNC_STAGES + 1 + HOLD_CYCLES;
  localparam int SHORT_MAX = DATA_DLY + 1;

  logic clk200 = 1'b0;
  always #2 clk200 = ~clk200;

  logic        rst_n;
  logic        a8_clk, a8_rw_n, a8_halt_n, a8_rst_n;
  logic [15:0] a8_addr, cfg_base, cfg_mask;
  logic [7:0]  a8_data;
  logic        cfg_claim_en, cfg_mpd_en, ovf_clr;
  logic        a8_extsel_n, a8_mpd_n, ovf, short_err;
  logic [7:0]  drop_cnt;

  a8_bus_sequencer_if evt_if();

  a8_bus_sequencer #(
    .SYNC_STAGES(SYNC_STAGES), .ADDR_DLY(ADDR_DLY), .DATA_DLY(DATA_DLY), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk200(clk200), .rst_n(rst_n),
    .a8_clk_i(a8_clk), .a8_rw_n_i(a8_rw_n), .a8_halt_n_i(a8_halt_n), .a8_rst_n_i(a8_rst_n),
    .a8_addr_i(a8_addr), .a8_data_i(a8_data),
    .cfg_base_i(cfg_base), .cfg_mask_i(cfg_mask),
    .cfg_claim_en_i(cfg_claim_en), .cfg_mpd_en_i(cfg_mpd_en), .ovf_clr_i(ovf_clr),
    .a8_extsel_n_o(a8_extsel_n), .a8_mpd_n_o(a8_mpd_n), .ovf_o(ovf),
    .drop_cnt_o(drop_cnt), .short_err_o(short_err),
    .evt(evt_if)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [25:0] exp_q[$];
  int exp_drops = 0;
  int exp_short = 0;
  int seen_short = 0;
  logic rand_ready_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endfunction

  // Reference model: claim window, math-pack range
  function automatic logic m_claim(input logic [15:0] a, input logic [15:0] base, input logic [15:0] mask,
                                   input logic en, input logic halt_n);
    return en && halt_n && ((a & mask) == (base & mask));
  endfunction

  function automatic logic m_mpd(input logic [15:0] a, input logic en);
    return en && (a >= 16'hD800) && (a <= 16'hDFFF);
  endfunction

  // Scoreboard: compare every accepted head event with the model queue
  always @(negedge clk200) begin
    logic [25:0] want;
    if (rst_n && short_err) seen_short++;
    if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL evt_unexpected: got 0x%0h required none",
                 {evt_if.evt_dma, evt_if.evt_rw_n, evt_if.evt_data, evt_if.evt_addr});
      end else begin
        want = exp_q.pop_front();
        check("evt_head", {6'd0, evt_if.evt_dma, evt_if.evt_rw_n, evt_if.evt_data, evt_if.evt_addr}, {6'd0, want});
      end
    end
  end

  task automatic run_cycle(input logic [15:0] addr, input logic [7:0] data, input logic rw_n,
                           input logic halt_n, input int high, input int low,
                           input logic exp_ext_n, input logic exp_mpd_n, input string tag);
    if (high > SHORT_MAX) begin
      if (exp_q.size() < 4) exp_q.push_back({~halt_n, rw_n, data, addr});
      else exp_drops++;
    end else begin
      exp_short++;
    end
    a8_addr = addr; a8_data = data; a8_rw_n = rw_n; a8_halt_n = halt_n; a8_clk = 1'b1;
    for (int t = 1; t <= high + low; t++) begin
      @(posedge clk200); #1;
      if (t == T_ASSERT - 1) begin
        check({tag, "_ext_pre"}, 32'(a8_extsel_n), 32'd1);
        check({tag, "_mpd_pre"}, 32'(a8_mpd_n), 32'd1);
      end
      if (t == T_ASSERT) begin
        check({tag, "_ext"}, 32'(a8_extsel_n), 32'(exp_ext_n));
        check({tag, "_mpd"}, 32'(a8_mpd_n), 32'(exp_mpd_n));
      end
      if (t == high + T_RELEASE - 1) begin
        check({tag, "_ext_hold"}, 32'(a8_extsel_n), 32'(exp_ext_n));
        check({tag, "_mpd_hold"}, 32'(a8_mpd_n), 32'(exp_mpd_n));
      end
      if (t == high + T_RELEASE) begin
        check({tag, "_ext_rel"}, 32'(a8_extsel_n), 32'd1);
        check({tag, "_mpd_rel"}, 32'(a8_mpd_n), 32'd1);
      end
      if (t == high) a8_clk = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk200);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        halt_n;
    logic [15:0] base;
    logic [15:0] mask;
    logic        claim_en;
    logic        mpd_en;
    int          high;
    logic        exp_ext_n;
    logic        exp_mpd_n;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] masks[5];

  initial begin
    vecs[0] = '{16'hD500, 8'h5A, 1'b0, 1'b1, 16'hD500, 16'hFF00, 1'b1, 1'b0, 56, 1'b0, 1'b1};
    vecs[1] = '{16'h0600, 8'hA9, 1'b1, 1'b1, 16'hD500, 16'hFF00, 1'b1, 1'b0, 56, 1'b1, 1'b1};
    vecs[2] = '{16'hD510, 8'h33, 1'b1, 1'b0, 16'hD500, 16'hFF00, 1'b1, 1'b0, 56, 1'b1, 1'b1};
    vecs[3] = '{16'hD800, 8'h11, 1'b1, 1'b1, 16'hD500, 16'hFF00, 1'b1, 1'b1, 56, 1'b1, 1'b0};
    vecs[4] = '{16'hDFFF, 8'h22, 1'b1, 1'b1, 16'hD500, 16'hFF00, 1'b1, 1'b1, 56, 1'b1, 1'b0};
    vecs[5] = '{16'hE000, 8'h44, 1'b1, 1'b1, 16'hD500, 16'hFF00, 1'b1, 1'b1, 56, 1'b1, 1'b1};
    vecs[6] = '{16'hD5C3, 8'h77, 1'b0, 1'b1, 16'hD500, 16'hFF00, 1'b1, 1'b1, 20, 1'b0, 1'b1};
    vecs[7] = '{16'hD5C3, 8'h78, 1'b0, 1'b1, 16'hD500, 16'hFF00, 1'b0, 1'b0, 56, 1'b1, 1'b1};
    vecs[8] = '{16'hD5AA, 8'hC3, 1'b1, 1'b1, 16'hD5AA, 16'hFFFF, 1'b1, 1'b0, 42, 1'b0, 1'b1};
    vecs[9] = '{16'hD9F0, 8'h0F, 1'b0, 1'b1, 16'hD800, 16'hF800, 1'b1, 1'b1, 60, 1'b0, 1'b0};
    masks[0] = 16'hFF00; masks[1] = 16'hF000; masks[2] = 16'hFFFF; masks[3] = 16'h0000; masks[4] = 16'hF800;

    rst_n = 1'b0;
    a8_clk = 1'b0; a8_rw_n = 1'b1; a8_halt_n = 1'b1; a8_rst_n = 1'b1;
    a8_addr = 16'h0000; a8_data = 8'h00;
    cfg_base = 16'h0000; cfg_mask = 16'h0000; cfg_claim_en = 1'b0; cfg_mpd_en = 1'b0;
    ovf_clr = 1'b0; evt_if.evt_ready = 1'b1;
    repeat (3) @(posedge clk200);
    #1;
    check("rst_extsel_n", 32'(a8_extsel_n), 32'd1);
    check("rst_mpd_n", 32'(a8_mpd_n), 32'd1);
    check("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst_evt_addr", 32'(evt_if.evt_addr), 32'd0);
    check("rst_evt_data", 32'(evt_if.evt_data), 32'd0);
    check("rst_evt_rw_n", 32'(evt_if.evt_rw_n), 32'd1);
    check("rst_evt_dma", 32'(evt_if.evt_dma), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_short_err", 32'(short_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk200);
    #1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      cfg_base = vecs[i].base; cfg_mask = vecs[i].mask;
      cfg_claim_en = vecs[i].claim_en; cfg_mpd_en = vecs[i].mpd_en;
      run_cycle(vecs[i].addr, vecs[i].data, vecs[i].rw_n, vecs[i].halt_n, vecs[i].high, 30,
                vecs[i].exp_ext_n, vecs[i].exp_mpd_n, $sformatf("vec%0d", i));
    end
    wait_drain("vec_drain");
    check("vec_short_cnt", 32'(seen_short), 32'(exp_short));

    // A8 reset asserted mid data phase: pins released, no event
    cfg_base = 16'hD500; cfg_mask = 16'hFF00; cfg_claim_en = 1'b1; cfg_mpd_en = 1'b0;
    a8_addr = 16'hD501; a8_data = 8'hEE; a8_rw_n = 1'b0; a8_halt_n = 1'b1; a8_clk = 1'b1;
    for (int t = 1; t <= 90; t++) begin
      @(posedge clk200); #1;
      if (t == T_ASSERT) check("a8rst_ext_on", 32'(a8_extsel_n), 32'd0);
      if (t == 20) a8_rst_n = 1'b0;
      if (t == 26) check("a8rst_ext_off", 32'(a8_extsel_n), 32'd1);
      if (t == 56) a8_clk = 1'b0;
      if (t == 60) check("a8rst_ext_off2", 32'(a8_extsel_n), 32'd1);
      if (t == 70) a8_rst_n = 1'b1;
    end
    check("a8rst_no_evt", 32'(evt_if.evt_valid), 32'd0);
    run_cycle(16'hD502, 8'h3C, 1'b1, 1'b1, 56, 30, 1'b0, 1'b1, "after_a8rst");
    wait_drain("a8rst_drain");

    // Overflow: six cycles with no consumer
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      run_cycle(16'hD500 + 16'(i), 8'h10 + 8'(i), 1'b0, 1'b1, 56, 30, 1'b0, 1'b1, $sformatf("ovf%0d", i));
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    check("ovf_valid", 32'(evt_if.evt_valid), 32'd1);
    check("ovf_head_addr", 32'(evt_if.evt_addr), 32'hD500);
    check("ovf_head_data", 32'(evt_if.evt_data), 32'h10);
    ovf_clr = 1'b1;
    @(posedge clk200); #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    evt_if.evt_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_empty", 32'(evt_if.evt_valid), 32'd0);

    // Randomized cycles against the model, consumer ready toggling randomly
    rand_ready_en = 1'b1;
    fork
      begin
        while (rand_ready_en) begin
          @(posedge clk200); #1;
          evt_if.evt_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int n = 0; n < 30; n++) begin
      logic [15:0] a;
      logic        hn, ce, me;
      int          hi;
      cfg_base = 16'($urandom);
      cfg_mask = masks[$urandom_range(0, 4)];
      ce = 1'($urandom_range(0, 1));
      me = 1'($urandom_range(0, 1));
      cfg_claim_en = ce; cfg_mpd_en = me;
      case ($urandom_range(0, 3))
        0, 1: a = (cfg_base & cfg_mask) | (16'($urandom) & ~cfg_mask);
        2:    a = 16'hD800 + 16'($urandom_range(0, 2047));
        default: a = 16'($urandom);
      endcase
      hn = ($urandom_range(0, 4) != 0);
      hi = ($urandom_range(0, 4) != 0) ? $urandom_range(44, 70) : $urandom_range(14, 40);
      run_cycle(a, 8'($urandom), 1'($urandom_range(0, 1)), hn, hi, $urandom_range(20, 40),
                ~m_claim(a, cfg_base, cfg_mask, ce, hn), ~m_mpd(a, me), $sformatf("rnd%0d", n));
    end
    rand_ready_en = 1'b0;
    @(posedge clk200); #1;
    evt_if.evt_ready = 1'b1;
    wait_drain("rnd_drain");
    check("final_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    check("final_ovf", 32'(ovf), 32'd0);
    check("final_short_cnt", 32'(seen_short), 32'(exp_short));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
